slt_serial_compare: RTL and testbench
=====================================

SLT_SERIAL_COMPARE -- requirements
Module: slt_serial_compare

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising clk edge.
REQ-003 SHALL have port start, input, 1 bit: request a compare; sampled only in IDLE.
REQ-004 SHALL have port a, input, 32 bits: left operand (rs value).
REQ-005 SHALL have port b, input, 32 bits: right operand (rt value).
REQ-006 SHALL have port is_unsigned, input, 1 bit: 1 selects sltu semantics, 0 selects slt semantics.
REQ-007 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result becomes valid.
REQ-009 SHALL have port lt, output, 1 bit: compare result; this is the single bit the datapath zero-extends to 32 bits for the slt/sltu writeback.
REQ-010 SHALL have port eq, output, 1 bit: high when a == b for the last completed compare.

Function
REQ-011 SHALL implement three states: IDLE, RUN and DONE.
REQ-012 IDLE with start=1 at an edge SHALL latch a, b and is_unsigned into internal registers, clear the borrow and the nonzero-difference flag, set the bit counter to 0, and go to RUN.
REQ-013 IDLE with start=0 SHALL hold all state; lt and eq SHALL keep their last values.
REQ-014 Each RUN edge SHALL process operand bit cnt, LSB first: diff = a[cnt] ^ b[cnt] ^ borrow; borrow_next = (~a[cnt] & b[cnt]) | (~(a[cnt] ^ b[cnt]) & borrow); nz |= diff.
REQ-015 Bit order SHALL be LSB to MSB. The counter is 5 bits and increments each RUN edge.
REQ-016 The RUN edge with cnt == 31 SHALL go to DONE and update lt and eq; the counter SHALL wrap to 0.
REQ-017 lt SHALL be borrow_out when is_unsigned=1, and borrow_out ^ a[31] ^ b[31] when is_unsigned=0; borrow_out is the borrow from bit 31.
REQ-018 eq SHALL be ~(nz | diff31).
REQ-019 DONE SHALL drive done=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge E32, and busy SHALL be high from after E0 until after E33.
REQ-021 lt and eq SHALL change only at the edge entering DONE, and SHALL stay stable until the next completion.
REQ-022 start SHALL be ignored in RUN and DONE; no queuing, no restart, and latched operands are unaffected.
REQ-023 Changes on a, b and is_unsigned after the start edge SHALL NOT affect the result.
REQ-024 start held high continuously SHALL give back-to-back compares: IDLE for one cycle, then a new compare, i.e. one result per 34 cycles.
REQ-025 busy and done SHALL be decoded directly from state registers, with no combinational path from inputs.

Reset
REQ-026 reset=1 at an edge SHALL force IDLE, counter 0, borrow 0, nz 0, busy 0, done 0, lt 0 and eq 0, regardless of state.
REQ-027 Reset mid-RUN SHALL abort the compare with no done pulse; lt and eq SHALL read 0.
REQ-028 reset takes priority over start at the same edge; start SHALL be ignored at that edge.

Verification
REQ-029 Signed negative: a=0xFFFFFFFF (-1), b=0x00000001, is_unsigned=0, start pulse -> done 32 cycles later with lt=1, eq=0; the same operands with is_unsigned=1 -> lt=0, eq=0.
REQ-030 Equal: a=b=0x80000000, is_unsigned=0 -> lt=0, eq=1; the same with is_unsigned=1 -> lt=0, eq=1.
REQ-031 Signed boundary: a=0x80000000, b=0x7FFFFFFF, is_unsigned=0 -> lt=1; is_unsigned=1 -> lt=0.
REQ-032 Operand stability: start with a=5 and b=9, then change a to 0xFFFFFFFF and b to 0 at the next cycle -> lt=1, eq=0 (latched values used); a second start asserted in RUN cycle 10 produces no extra done.
REQ-033 Reset abort: start, then reset=1 at RUN cycle 15 -> next cycle busy=0, done=0, lt=0, eq=0; a following compare a=3, b=3 completes normally with eq=1.
REQ-034 Throughput: start held high for 100 cycles with a=1, b=2, is_unsigned=1 -> done pulses at cycles 33 and 67 relative to the first start edge, each with lt=1 and busy low for exactly one cycle between them.

Source files
------------

// File: rtl/slt_serial_compare.sv
// slt_serial_compare
//
// Bit-serial signed/unsigned less-than comparator for the slt/sltu
// instructions. A compare runs a ripple-borrow subtraction a - b one bit
// per clock, LSB first, over 32 RUN cycles. The final borrow gives the
// unsigned result. The signed result is that borrow corrected by the two
// operand sign bits. A running OR of the difference bits gives equality.
//
// Ports
//   clk         : single clock, all state changes on the rising edge
//   reset       : synchronous active-high reset
//   start       : request a compare (only looked at in IDLE)
//   a, b        : 32-bit operands (rs, rt)
//   is_unsigned : 1 = sltu semantics, 0 = slt semantics
//   busy        : high while a compare is in RUN or DONE
//   done        : one-cycle pulse when lt/eq become valid
//   lt          : compare result bit (zero-extended by the datapath)
//   eq          : a == b for the last completed compare

module slt_serial_compare (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_unsigned,
  output logic        busy,
  output logic        done,
  output logic        lt,
  output logic        eq
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        unsigned_reg;
  logic [4:0]  cnt;
  logic        borrow;
  logic        nz;

  // Current bit slice of the subtraction a - b, taken from the latched
  // operands so that input changes after start cannot affect the result.
  logic a_bit;
  logic b_bit;
  logic diff;
  logic borrow_next;

  assign a_bit       = a_reg[cnt];
  assign b_bit       = b_reg[cnt];
  assign diff        = a_bit ^ b_bit ^ borrow;
  assign borrow_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow);

  // Status outputs come straight from the state register, so there is
  // no combinational path from any input to busy or done.
  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      unsigned_reg <= 1'b0;
      cnt          <= '0;
      borrow       <= 1'b0;
      nz           <= 1'b0;
      lt           <= 1'b0;
      eq           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg        <= a;
            b_reg        <= b;
            unsigned_reg <= is_unsigned;
            cnt          <= '0;
            borrow       <= 1'b0;
            nz           <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          borrow <= borrow_next;
          nz     <= nz | diff;
          // The 5-bit counter wraps from 31 back to 0 on the last bit.
          cnt    <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            // The borrow out of bit 31 is the unsigned a < b. For the
            // signed compare, flipping it by both sign bits gives the
            // two's-complement ordering.
            if (unsigned_reg) begin
              lt <= borrow_next;
            end else begin
              lt <= borrow_next ^ a_reg[31] ^ b_reg[31];
            end
            eq    <= ~(nz | diff);
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slt_serial_compare.sv
// tb_slt_serial_compare
//
// Directed testbench for slt_serial_compare. The bench drives inputs and
// samples outputs on the falling clock edge. Expected values are
// hand-computed constants.
//
// Ports: none (top-level bench).

module tb_slt_serial_compare;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_unsigned;
  logic        busy;
  logic        done;
  logic        lt;
  logic        eq;

  int check_count;
  int pass_count;

  slt_serial_compare dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .is_unsigned (is_unsigned),
    .busy        (busy),
    .done        (done),
    .lt          (lt),
    .eq          (eq)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its expected value and counts it.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    check_count++;
    if (obs === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one full compare from a start pulse. It checks the latency to
  // done, the result, and the return to idle one cycle after done.
  task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                               input logic vu, input logic exp_lt,
                               input logic exp_eq, input string tag);
    int n;
    @(negedge clk);
    a = va;
    b = vb;
    is_unsigned = vu;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    // After E0, done is seen on the falling edge that follows E32.
    checkOutput({tag, "_latency"}, n, 32'd32);
    checkOutput({tag, "_lt"}, {31'd0, lt}, {31'd0, exp_lt});
    checkOutput({tag, "_eq"}, {31'd0, eq}, {31'd0, exp_eq});
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int done_seen;
    int done_cycle [2];
    int busy_low;
    logic lt_at_done;
    logic eq_at_done;
    logic lt_tp [2];

    check_count = 0;
    pass_count  = 0;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    is_unsigned = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_lt",   {31'd0, lt},   32'd0);
    checkOutput("rst_eq",   {31'd0, eq},   32'd0);

    // Signed and unsigned vectors.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0, "neg_s");
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0, "neg_u");
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, "eq_s");
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b1, "eq_u");
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "bnd_s");
    applyStimulus(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, "bnd_u");

    // Operand stability, with a stray start pulse in RUN cycle 10.
    @(negedge clk);
    a = 32'd5;
    b = 32'd9;
    is_unsigned = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'd0;
    done_seen = 0;
    lt_at_done = 1'b0;
    eq_at_done = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      start = (k == 9);
      if (done) begin
        done_seen++;
        lt_at_done = lt;
        eq_at_done = eq;
      end
    end
    start = 1'b0;
    checkOutput("stab_done_count", done_seen, 32'd1);
    checkOutput("stab_lt", {31'd0, lt_at_done}, 32'd1);
    checkOutput("stab_eq", {31'd0, eq_at_done}, 32'd0);
    checkOutput("stab_idle", {31'd0, busy}, 32'd0);

    // Reset abort at RUN cycle 15 (lt is 1 from the previous compare).
    @(negedge clk);
    a = 32'd1;
    b = 32'd2;
    is_unsigned = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_lt",   {31'd0, lt},   32'd0);
    checkOutput("abort_eq",   {31'd0, eq},   32'd0);
    applyStimulus(32'd3, 32'd3, 1'b0, 1'b0, 1'b1, "abort_next");

    // Reset has priority over start at the same edge.
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    a = 32'd1;
    b = 32'd2;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    checkOutput("prio_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("prio_busy2", {31'd0, busy}, 32'd0);

    // Throughput: start held for 100 cycles. The cycle number is
    // edge index + 1, so done is expected in cycles 33 and 67.
    a = 32'd1;
    b = 32'd2;
    is_unsigned = 1'b1;
    start = 1'b1;
    done_seen = 0;
    busy_low = 0;
    done_cycle[0] = -1;
    done_cycle[1] = -1;
    lt_tp[0] = 1'b0;
    lt_tp[1] = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        if (done_seen < 2) begin
          done_cycle[done_seen] = k + 1;
          lt_tp[done_seen] = lt;
        end
        done_seen++;
      end
      if (!busy && k > 32 && k < 66) busy_low++;
    end
    start = 1'b0;
    checkOutput("tp_done_count", done_seen, 32'd2);
    checkOutput("tp_done_cycle0", done_cycle[0], 32'd33);
    checkOutput("tp_done_cycle1", done_cycle[1], 32'd67);
    checkOutput("tp_lt0", {31'd0, lt_tp[0]}, 32'd1);
    checkOutput("tp_lt1", {31'd0, lt_tp[1]}, 32'd1);
    checkOutput("tp_busy_gap", busy_low, 32'd1);

    // Let the third, already-started compare drain.
    repeat (40) @(negedge clk);
    checkOutput("tp_drain_idle", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
